vram_arbiter: RTL

- Shares the single-port synchronous video RAM between the tile renderer's fetch port (fixed-timing, absolute priority) and a CPU/loader port (request/acknowledge, best effort).
- Sits between the tile renderer, the CPU bus and the RAM instance. Owns the RAM address, write-data and write-enable pins.
- Tracks in-flight accesses with a 2-stage owner tag so read data returns to the correct requester.
- Flags CPU starvation.

---
 rtl/vram_arbiter_if.sv | 35 +++
 rtl/vram_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM macro.
// The arbiter uses the slave side; the bench (requesters + RAM model) uses master.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_starve;
  logic              starve_clr;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, starve_clr, ram_dout,
    output vid_data, vid_valid, cpu_dout, cpu_ack, cpu_starve, ram_addr, ram_din, ram_we
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, starve_clr, ram_dout,
    input  vid_data, vid_valid, cpu_dout, cpu_ack, cpu_starve, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer fetches have absolute priority, the CPU
// port is served best-effort with one access in flight and a starvation flag.
module vram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU_R, TAG_CPU_W} tag_e;

  state_e            state_q, state_d;
  tag_e              tag0_q, tag0_d, tag1_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              starve_q, starve_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              cpu_grant_c;
  logic              cpu_done_c;
  logic              waiting_c;
  logic [WAIT_W-1:0] wait_inc_c;

  // Grant, pipeline tagging, CPU completion and starvation tracking
  always_comb begin
    state_d    = state_q;
    tag0_d     = TAG_NONE;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    cpu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    wait_d     = wait_q;
    starve_d   = starve_q;

    cpu_done_c  = (tag1_q == TAG_CPU_R) || (tag1_q == TAG_CPU_W);
    // The ack cycle is skipped so a held cpu_req is not re-granted before the CPU reacts
    cpu_grant_c = !bus.vid_req && (state_q == ST_IDLE) && bus.cpu_req && !cpu_ack_q;
    waiting_c   = bus.cpu_req && (state_q == ST_IDLE) && !cpu_ack_q && !cpu_grant_c;
    wait_inc_c  = (wait_q == MAX_WAIT_V) ? wait_q : wait_q + WAIT_W'(1);

    if (bus.vid_req) begin
      ram_addr_d = bus.vid_addr;
      tag0_d     = TAG_VID;
    end else if (cpu_grant_c) begin
      ram_addr_d = bus.cpu_addr;
      ram_din_d  = bus.cpu_din;
      ram_we_d   = bus.cpu_we;
      tag0_d     = bus.cpu_we ? TAG_CPU_W : TAG_CPU_R;
    end

    case (state_q)
      ST_IDLE: if (cpu_grant_c) state_d = ST_BUSY;
      ST_BUSY: if (cpu_done_c)  state_d = ST_IDLE;
    endcase

    if (cpu_done_c) begin
      cpu_ack_d = 1'b1;
      if (tag1_q == TAG_CPU_R) cpu_dout_d = bus.ram_dout;
    end

    if (cpu_grant_c || !bus.cpu_req) wait_d = '0;
    else if (waiting_c)              wait_d = wait_inc_c;

    // Set beats clear when both happen together
    if (waiting_c && (wait_inc_c == MAX_WAIT_V)) starve_d = 1'b1;
    else if (bus.starve_clr)                     starve_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tag0_q     <= TAG_NONE;
      tag1_q     <= TAG_NONE;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      starve_q   <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag0_q;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_dout_q <= cpu_dout_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_din_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.cpu_starve = starve_q;
  assign bus.vid_data   = bus.ram_dout;
  assign bus.vid_valid  = (tag1_q == TAG_VID);

endmodule
